// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core/status outputs of the boot loader.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  // Byte source / supervisor side.
  modport master (
    output s_valid, s_data, restart,
    input  s_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error, words_loaded
  );

  // Loader side.
  modport slave (
    input  s_valid, s_data, restart,
    output s_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image as a byte stream, writes it word by word into
// instruction memory and holds the core in reset until the image checksum verifies.
// Frame: N[7:0], N[15:8], 4*N little-endian payload bytes, then XOR of all preceding bytes.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input logic                clk,
  input logic                rst,
  imem_boot_loader_if.slave  bus
);

  localparam logic [16:0]     MaxWords = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] WlOne    = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        xor_q, xor_d;
  logic [23:0]       lanes_q, lanes_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        s_ready;
  logic        take;
  logic [16:0] hdr_n;
  logic        last_word;

  // Ready is a pure decode of the registered state.
  always_comb begin
    s_ready = (state_q == StHdrLo) || (state_q == StHdrHi) ||
              (state_q == StData)  || (state_q == StCsum);
  end

  assign take  = bus.s_valid && s_ready;
  assign hdr_n = {1'b0, bus.s_data, n_q[7:0]};
  // words_loaded already counts every earlier word when the 4th byte of the next one arrives.
  assign last_word = (17'(words_loaded_q) == (17'(n_q) - 17'd1));

  // Next-state and output-register computation.
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    byte_idx_d     = byte_idx_q;
    xor_d          = xor_q;
    lanes_d        = lanes_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;
    core_rst_d     = core_rst_q;
    done_d         = done_q;
    error_d        = error_q;

    unique case (state_q)
      StIdle: begin
        state_d = StHdrLo;
      end

      StHdrLo: begin
        if (take) begin
          n_d     = {8'h00, bus.s_data};
          xor_d   = xor_q ^ bus.s_data;
          state_d = StHdrHi;
        end
      end

      StHdrHi: begin
        if (take) begin
          n_d   = {bus.s_data, n_q[7:0]};
          xor_d = xor_q ^ bus.s_data;
          if (hdr_n > MaxWords) begin
            state_d = StErr;
            error_d = 1'b1;
          end else if (hdr_n == 17'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        if (take) begin
          xor_d      = xor_q ^ bus.s_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: lanes_d[7:0]   = bus.s_data;
            2'd1: lanes_d[15:8]  = bus.s_data;
            2'd2: lanes_d[23:16] = bus.s_data;
            default: begin
              imem_we_d      = 1'b1;
              imem_addr_d    = words_loaded_q[ADDR_W-1:0];
              imem_wdata_d   = {bus.s_data, lanes_q};
              words_loaded_d = words_loaded_q + WlOne;
              if (last_word) begin
                state_d = StCsum;
              end
            end
          endcase
        end
      end

      StCsum: begin
        if (take) begin
          if (bus.s_data == xor_q) begin
            state_d    = StDone;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = StErr;
            error_d = 1'b1;
          end
        end
      end

      StDone, StErr: begin
        if (bus.restart) begin
          state_d        = StHdrLo;
          n_d            = 16'd0;
          byte_idx_d     = 2'd0;
          xor_d          = 8'd0;
          words_loaded_d = '0;
          core_rst_d     = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      n_q            <= 16'd0;
      byte_idx_q     <= 2'd0;
      xor_q          <= 8'd0;
      lanes_q        <= 24'd0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= 32'd0;
      words_loaded_q <= '0;
      core_rst_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      byte_idx_q     <= byte_idx_d;
      xor_q          <= xor_d;
      lanes_q        <= lanes_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      words_loaded_q <= words_loaded_d;
      core_rst_q     <= core_rst_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign bus.s_ready      = s_ready;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.core_rst     = core_rst_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus random frames, checked
// against a frame-level model of the expected writes and final status.
module tb_imem_boot_loader;

  localparam int unsigned AW       = 4;
  localparam int unsigned MaxWords = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(AW)) bus ();

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Record every memory write; the core must be held in reset while writes happen.
  always @(negedge clk) begin
    if (rst && bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(bus.imem_addr));
      wr_data_q.push_back(bus.imem_wdata);
      check("core_rst_during_write", 32'(bus.core_rst), 32'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Offer one byte, optionally after random idle gaps; returns on a negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int tries;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        @(negedge clk);
      end
      bus.restart = 1'($urandom_range(0, 1));  // must be ignored mid-load
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    tries = 0;
    while (!bus.s_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom);
    bus.restart = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit gaps, input string name);
    int unsigned n;
    bit          oversize;
    bit          ok;
    int          nb;
    int          t;
    logic [7:0]  x;
    logic [31:0] w;
    n        = {f[1], f[0]};
    oversize = n > MaxWords;
    nb       = oversize ? 2 : 3 + 4 * int'(n);
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < nb; i++) send_byte(f[i], gaps);
    x = 8'd0;
    for (int i = 0; i < nb - 1; i++) x ^= f[i];
    ok = !oversize && (f[nb-1] == x);
    t = 0;
    while (!(bus.done || bus.error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, ":done"},     32'(bus.done),     32'(ok));
    check({name, ":error"},    32'(bus.error),    32'(!ok));
    check({name, ":core_rst"}, 32'(bus.core_rst), 32'(!ok));
    check({name, ":s_ready"},  32'(bus.s_ready),  32'd0);
    check({name, ":words"},    32'(bus.words_loaded), oversize ? 32'd0 : 32'(n));
    check({name, ":nwrites"},  32'(wr_addr_q.size()), oversize ? 32'd0 : 32'(n));
    if (!oversize) begin
      for (int i = 0; i < int'(n) && i < wr_addr_q.size(); i++) begin
        w = {f[5+4*i], f[4+4*i], f[3+4*i], f[2+4*i]};
        check({name, ":addr"}, 32'(wr_addr_q[i]), 32'(i));
        check({name, ":data"}, wr_data_q[i], w);
      end
    end
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    check("restart:core_rst", 32'(bus.core_rst),     32'd1);
    check("restart:done",     32'(bus.done),         32'd0);
    check("restart:error",    32'(bus.error),        32'd0);
    check("restart:words",    32'(bus.words_loaded), 32'd0);
    check("restart:s_ready",  32'(bus.s_ready),      32'd1);
  endtask

  // Build a frame with N words of random payload; the checksum is optionally corrupted.
  task automatic gen_frame(input int unsigned n, input bit good, output logic [7:0] f[$]);
    logic [7:0] x;
    f = {};
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    if (n <= MaxWords) begin
      for (int i = 0; i < 4 * int'(n); i++) f.push_back(8'($urandom));
    end
    x = 8'd0;
    foreach (f[i]) x ^= f[i];
    f.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
  endtask

  logic [7:0] t1[$];
  logic [7:0] t2[$];
  logic [7:0] t3[$];
  logic [7:0] t4[$];
  logic [7:0] fr[$];

  initial begin
    t1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    t2 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
    t3 = '{8'h00, 8'h00, 8'h00};
    t4 = '{8'h11, 8'h00, 8'h00};
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.restart = 1'b0;

    repeat (2) @(negedge clk);
    check("rst:s_ready",  32'(bus.s_ready),      32'd0);
    check("rst:imem_we",  32'(bus.imem_we),      32'd0);
    check("rst:addr",     32'(bus.imem_addr),    32'd0);
    check("rst:wdata",    bus.imem_wdata,        32'd0);
    check("rst:core_rst", 32'(bus.core_rst),     32'd1);
    check("rst:done",     32'(bus.done),         32'd0);
    check("rst:error",    32'(bus.error),        32'd0);
    check("rst:words",    32'(bus.words_loaded), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_to_hdr:s_ready", 32'(bus.s_ready), 32'd1);

    run_frame(t1, 1'b0, "t1");
    do_restart();
    run_frame(t2, 1'b0, "t2_badcsum");
    do_restart();
    run_frame(t3, 1'b0, "t3_empty");
    do_restart();
    run_frame(t4, 1'b0, "t4_oversize");
    do_restart();
    run_frame(t1, 1'b1, "t5_gaps");

    // Reset in the middle of a load, then reload cleanly.
    do_restart();
    for (int i = 0; i < 5; i++) send_byte(t1[i], 1'b0);
    rst = 1'b0;
    #1;
    check("midrst:core_rst", 32'(bus.core_rst),     32'd1);
    check("midrst:words",    32'(bus.words_loaded), 32'd0);
    check("midrst:s_ready",  32'(bus.s_ready),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame(t1, 1'b0, "t6_reload");
    do_restart();
    run_frame(t3, 1'b0, "t6_empty");

    for (int k = 0; k < 8; k++) begin
      do_restart();
      gen_frame($urandom_range(0, MaxWords + 1), $urandom_range(0, 3) != 0, fr);
      run_frame(fr, 1'($urandom_range(0, 1)), "rand");
    end

    do_restart();
    gen_frame(MaxWords, 1'b1, fr);
    run_frame(fr, 1'b1, "full");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
